// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage OTTER pipeline: forwarding selects,
// stall/flush enables, and a freeze FSM for data-memory accesses awaiting acknowledge.

module hazard_fwd_sel (
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic       regWriteM,
    input  logic [4:0] rdW,
    input  logic       regWriteW,
    output logic [1:0] fwd
);
    // M holds the younger result, so it wins over W.
    always_comb begin
        fwd = 2'b00;
        if (regWriteM && rdM != 5'd0 && rdM == rsE)
            fwd = 2'b10;
        else if (regWriteW && rdW != 5'd0 && rdW == rsE)
            fwd = 2'b01;
    end
endmodule

module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);
    localparam int NUM_SRC = 2;
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t     state, stateNext;
    logic [7:0] waitCnt, waitCntNext;
    logic       errSet;
    logic       timeoutHit, memHold, loadUse;

    logic [NUM_SRC-1:0][4:0] rsE;
    logic [NUM_SRC-1:0][1:0] fwdSel;

    assign rsE = {Rs2E, Rs1E};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        hazard_fwd_sel u_fwd (
            .rsE       (rsE[i]),
            .rdM       (RdM),
            .regWriteM (RegWriteM),
            .rdW       (RdW),
            .regWriteW (RegWriteW),
            .fwd       (fwdSel[i])
        );
    end

    assign ForwardAE = fwdSel[0];
    assign ForwardBE = fwdSel[1];

    assign timeoutHit = (state == MEM_WAIT) && (waitCnt == TO_LAST);
    assign memHold    = MemReqM && !MemAckM && !timeoutHit;
    assign loadUse    = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);

    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        stateNext   = state;
        waitCntNext = waitCnt;
        errSet      = 1'b0;

        // Gating on RST_N keeps every enable low while reset is held, whatever the inputs.
        if (RST_N) begin
            if (memHold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (loadUse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end

        case (state)
            RUN: begin
                if (MemReqM && !MemAckM) begin
                    stateNext   = MEM_WAIT;
                    waitCntNext = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (MemAckM) begin
                    stateNext = RUN;
                end else if (timeoutHit) begin
                    stateNext = RUN;
                    errSet    = 1'b1;
                end else begin
                    waitCntNext = waitCnt + 8'd1;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= RUN;
            waitCnt    <= 8'd0;
            MemErr     <= 1'b0;
            StallCount <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (errSet)
                MemErr <= 1'b1;
            if (StallF && StallCount != '1)
                StallCount <= StallCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then randomized traffic,
// checked against a cycle-level behavioural model of the hazard rules.

module tb_pipeline_hazard_ctrl;
    localparam int T     = 4;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST_N;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [CW-1:0] StallCount;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .StallCount(StallCount)
    );

    typedef struct {
        int fa, fb;
        int sF, sD, sE, sM, fD, fE, fW, err, cnt;
    } exp_t;

    exp_t q[$];

    // Model state: cycles the current access has already been held, sticky error, stall tally.
    int mHeld = 0;
    int mErr  = 0;
    int mCnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwdOf(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    task automatic clr();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemAckM = 0;
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic step();
        exp_t e;
        bit hold, lu;
        hold = MemReqM && !MemAckM && (mHeld < T);
        lu   = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        e.fa = fwdOf(Rs1E);
        e.fb = fwdOf(Rs2E);
        e.sF = 0; e.sD = 0; e.sE = 0; e.sM = 0; e.fD = 0; e.fE = 0; e.fW = 0;
        if (hold) begin
            e.sF = 1; e.sD = 1; e.sE = 1; e.sM = 1; e.fW = 1;
        end else if (PCSrcE) begin
            e.fD = 1; e.fE = 1;
        end else if (lu) begin
            e.sF = 1; e.sD = 1; e.fE = 1;
        end
        e.err = mErr;
        e.cnt = mCnt;
        q.push_back(e);
        @(posedge CLK);
        if (e.sF && mCnt < SAT) mCnt++;
        if (MemReqM && !MemAckM) begin
            if (mHeld == T) begin
                mErr  = 1;
                mHeld = 0;
            end else begin
                mHeld++;
            end
        end else begin
            mHeld = 0;
        end
        #1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ForwardAE", int'(ForwardAE), e.fa);
            chk("ForwardBE", int'(ForwardBE), e.fb);
            chk("StallF", int'(StallF), e.sF);
            chk("StallD", int'(StallD), e.sD);
            chk("StallE", int'(StallE), e.sE);
            chk("StallM", int'(StallM), e.sM);
            chk("FlushD", int'(FlushD), e.fD);
            chk("FlushE", int'(FlushE), e.fE);
            chk("FlushW", int'(FlushW), e.fW);
            chk("MemErr", int'(MemErr), e.err);
            chk("StallCount", int'(StallCount), e.cnt);
        end
    end

    task automatic chkQuiet(input string tag);
        chk({tag, "_stalls"}, int'({StallF, StallD, StallE, StallM}), 0);
        chk({tag, "_flushes"}, int'({FlushD, FlushE, FlushW}), 0);
        chk({tag, "_MemErr"}, int'(MemErr), 0);
        chk({tag, "_StallCount"}, int'(StallCount), 0);
    endtask

    initial begin
        int accK, lat;
        clr();
        RST_N = 1'b0;
        MemReqM = 1; PCSrcE = 1;
        #3 chkQuiet("reset");
        clr();
        #4 RST_N = 1'b1;
        @(posedge CLK); #1;

        // forwarding, M over W, then W when RdM is x0
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
        step();
        RdM = 0;
        step();

        // load-use for one cycle, then the x0 destination case
        clr(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        step();
        clr(); step();
        ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
        step();

        // branch beats load-use
        clr(); ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1;
        step();

        // 3-cycle memory wait then ack
        clr(); MemReqM = 1;
        repeat (3) step();
        MemAckM = 1; step();
        clr(); step();

        // branch held across a wait is flushed only in the ack cycle
        MemReqM = 1; PCSrcE = 1;
        repeat (3) step();
        MemAckM = 1; step();
        clr(); step();

        // ack arrives in the timeout cycle: no error
        MemReqM = 1;
        repeat (T) step();
        MemAckM = 1; step();
        clr(); step();

        // timeout: T stall cycles, release with sticky error
        MemReqM = 1;
        repeat (T + 1) step();
        clr(); repeat (2) step();

        // reset while frozen in the wait state
        MemReqM = 1;
        repeat (2) step();
        PCSrcE = 1;
        #2 RST_N = 1'b0;
        #1 chkQuiet("midwait_reset");
        #3 clr(); RST_N = 1'b1;
        mHeld = 0; mErr = 0; mCnt = 0;
        @(posedge CLK); #1;
        MemReqM = 1; MemAckM = 1; step();
        clr(); step();

        // randomized traffic; memory accesses keep MemReqM up until ack or timeout
        accK = -1; lat = 0;
        repeat (400) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE    = ($urandom_range(0, 7) == 0);
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            if (accK < 0 && $urandom_range(0, 3) == 0) begin
                accK = 0;
                lat  = $urandom_range(0, 6);
            end
            MemReqM = (accK >= 0);
            MemAckM = (accK >= 0) && (accK == lat);
            step();
            if (accK >= 0) begin
                if (accK == lat || accK == T) accK = -1;
                else accK++;
            end
        end

        clr(); step();
        @(negedge CLK); #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
